// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result signals of the ALU command sequencer.
// The slave modport is the sequencer; the master modport is its environment.
interface alu_cmd_sequencer_if #(
    parameter int CW = 3
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [3:0]    cmd_a;
    logic [3:0]    cmd_b;
    logic [2:0]    cmd_sel;

    logic [3:0]    alu_a;
    logic [3:0]    alu_b;
    logic [2:0]    alu_sel;
    logic [7:0]    alu_out;
    logic          alu_cflag;
    logic          alu_zflag;

    logic          res_valid;
    logic          res_ready;
    logic [7:0]    res_data;
    logic          res_cflag;
    logic          res_zflag;
    logic [2:0]    res_sel;
    logic          res_err;

    logic [CW-1:0] cmd_count;
    logic          busy;

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_sel,
        input  alu_out, alu_cflag, alu_zflag,
        input  res_ready,
        output cmd_ready,
        output alu_a, alu_b, alu_sel,
        output res_valid, res_data, res_cflag, res_zflag, res_sel, res_err,
        output cmd_count, busy
    );

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_sel,
        output alu_out, alu_cflag, alu_zflag,
        output res_ready,
        input  cmd_ready,
        input  alu_a, alu_b, alu_sel,
        input  res_valid, res_data, res_cflag, res_zflag, res_sel, res_err,
        input  cmd_count, busy
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Issue stage for the 4-bit combinational ALU: queues commands, issues one at a
// time on registered operands, captures the result and traps divide-by-zero.
module alu_cmd_sequencer #(
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input logic                clk,
    input logic                rst,
    alu_cmd_sequencer_if.slave bus
);
    localparam int         AW     = $clog2(DEPTH);
    localparam logic [2:0] OP_DIV = 3'b011;

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] sel;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    cmd_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    state_t        state;
    state_t        state_next;

    cmd_t head;
    logic full;
    logic empty;
    logic push;
    logic pop;
    logic head_trap;
    logic issue;
    logic trap;
    logic capture;
    logic retire;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign push      = bus.cmd_valid && !full;
    assign head      = mem[rd_ptr];
    assign head_trap = (head.sel == OP_DIV) && (head.b == 4'd0);

    assign bus.cmd_ready = !full;
    assign bus.cmd_count = count;
    assign bus.busy      = (state != IDLE) || !empty;

    // NOTE: the queue storage has no reset; only the pointers and count do,
    // so stale entries are never observed and the array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel};
        end
    end

    // NOTE: every signal gets a default before the case, so no path leaves a
    // value unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        issue      = 1'b0;
        trap       = 1'b0;
        capture    = 1'b0;
        retire     = 1'b0;
        case (state)
            IDLE, DONE: begin
                // DONE only moves on once the held result has been taken.
                if (state == IDLE || (bus.res_valid && bus.res_ready)) begin
                    if (!empty) begin
                        pop        = 1'b1;
                        trap       = head_trap;
                        issue      = !head_trap;
                        state_next = head_trap ? DONE : EXEC;
                    end else if (state == DONE) begin
                        retire     = 1'b1;
                        state_next = IDLE;
                    end
                end
            end
            EXEC: begin
                capture    = 1'b1;
                state_next = DONE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_sel   <= '0;
            bus.res_valid <= 1'b0;
            bus.res_data  <= '0;
            bus.res_cflag <= 1'b0;
            bus.res_zflag <= 1'b0;
            bus.res_sel   <= '0;
            bus.res_err   <= 1'b0;
        end else begin
            state <= state_next;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);

            if (issue) begin
                bus.alu_a     <= head.a;
                bus.alu_b     <= head.b;
                bus.alu_sel   <= head.sel;
                bus.res_valid <= 1'b0;
            end
            // Divide-by-zero never reaches the ALU; the fixed trap result is
            // presented directly and may replace a just-consumed result.
            if (trap) begin
                bus.res_data  <= 8'hFF;
                bus.res_cflag <= 1'b1;
                bus.res_zflag <= 1'b0;
                bus.res_sel   <= OP_DIV;
                bus.res_err   <= 1'b1;
                bus.res_valid <= 1'b1;
            end
            if (capture) begin
                bus.res_data  <= bus.alu_out;
                bus.res_cflag <= bus.alu_cflag;
                bus.res_zflag <= bus.alu_zflag;
                bus.res_sel   <= bus.alu_sel;
                bus.res_err   <= 1'b0;
                bus.res_valid <= 1'b1;
            end
            if (retire) bus.res_valid <= 1'b0;
        end
    end
endmodule
